// File: rtl/ddr_rw_pkg.sv
// Constants shared by the DDR3 TS packet writer and reader: address map widths,
// packet geometry and the reader's FSM state type.
package ddr_rw_pkg;

    localparam int DDR3_ADDR_WIDTH = 28;
    localparam int PROG_BIT_WIDTH  = 9;
    localparam int ADDR_WIDTH      = 20 - PROG_BIT_WIDTH;
    localparam int PKT_WORDS       = 47;

    function automatic int nbeats(input int words);
        return (words + 3) / 4;
    endfunction

    localparam int NBEATS          = nbeats(PKT_WORDS);
    localparam int LAST_BEAT_WORDS = PKT_WORDS - 4 * (NBEATS - 1);
    localparam int BEAT_CNT_WIDTH  = 4;
    // Zero padding above the program field: 28 - 9 - 11 - 4 - 3 = 1 bit.
    localparam int ADDR_PAD        = DDR3_ADDR_WIDTH - PROG_BIT_WIDTH - ADDR_WIDTH - BEAT_CNT_WIDTH - 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } rd_state_t;

endpackage

// File: rtl/ddr_rd_beat_fifo.sv
// First-word-fall-through beat buffer: head shows the oldest entry while not
// empty; push and pop may happen in the same cycle.
module ddr_rd_beat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 128
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           push,
    input  logic [WIDTH-1:0]               push_data,
    input  logic                           pop,
    output logic [WIDTH-1:0]               head,
    output logic                           empty,
    output logic [$clog2(DEPTH+1)-1:0]     count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= (wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= (rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ddr_read_bit128to32.sv
// Reads one stored TS packet per command from DDR3 as 128-bit beats and
// serializes it to 32-bit TS words. Optional marker check: DDR_RD_MARKER_CHECK_EN.
module ddr_read_bit128to32
    import ddr_rw_pkg::*;
#(
    parameter int FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       rd_cmd_valid,
    input  logic [PROG_BIT_WIDTH-1:0]  rd_cmd_prog,
    output logic                       rd_cmd_ready,
    output logic                       ddr_rd_req,
    output logic [DDR3_ADDR_WIDTH-1:0] ddr_rd_addr,
    input  logic                       ddr_rd_ack,
    input  logic [127:0]               ddr_rd_data,
    input  logic                       ddr_rd_data_valid,
    output logic [31:0]                ts_out_data,
    output logic                       ts_out_valid,
    output logic                       ts_out_start,
    output logic                       ts_out_end,
    output logic                       pkt_err,
    output rd_state_t                  dbg_state
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int NPROG = 1 << PROG_BIT_WIDTH;

    // Handshakes: a command transfers when rd_cmd_valid && rd_cmd_ready at a clock
    // edge; a beat request transfers when ddr_rd_req && ddr_rd_ack, and req/addr
    // hold steady until then; returned beats have no backpressure.
    rd_state_t                  state, next_state;
    logic                       ready_q;
    logic                       cmd_accept;
    logic [PROG_BIT_WIDTH-1:0]  prog_q;
    logic [BEAT_CNT_WIDTH-1:0]  beat_cnt;
    logic [CNT_W-1:0]           in_flight;
    logic [CNT_W-1:0]           fifo_count;
    logic [ADDR_WIDTH-1:0]      rd_ptr_h [NPROG];
    logic                       credit_ok;
    logic                       issue_fire;
    logic                       last_issue;
    logic                       beat_push;
    logic                       beat_pop;
    logic [127:0]               fifo_head;
    logic                       fifo_empty;
    logic [1:0]                 word_idx;
    logic [BEAT_CNT_WIDTH-1:0]  ser_beat;
    logic                       ser_valid;
    logic                       ser_first;
    logic                       ser_beat_last;
    logic                       ser_word_last;
    logic                       ser_pkt_end;
    logic [31:0]                ser_word;
    logic                       drop_now;

    assign rd_cmd_ready = ready_q;
    assign dbg_state    = state;

    // Requests stop once buffered plus outstanding beats would fill the FIFO,
    // so every returned beat always has a slot.
    assign credit_ok   = ({1'b0, in_flight} + {1'b0, fifo_count}) < (CNT_W + 1)'(FIFO_DEPTH);
    assign ddr_rd_req  = (state == ST_ISSUE) && credit_ok;
    assign ddr_rd_addr = {{ADDR_PAD{1'b0}}, prog_q, rd_ptr_h[prog_q], beat_cnt, 3'b000};
    assign issue_fire  = ddr_rd_req && ddr_rd_ack;
    assign last_issue  = (beat_cnt == BEAT_CNT_WIDTH'(NBEATS - 1));
    assign beat_push   = ddr_rd_data_valid && ((state == ST_ISSUE) || (state == ST_DRAIN));

    always_comb begin
        next_state = state;
        cmd_accept = 1'b0;
        case (state)
            ST_IDLE: begin
                if (rd_cmd_valid && ready_q) begin
                    cmd_accept = 1'b1;
                    next_state = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (issue_fire && last_issue) begin
                    next_state = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (ser_pkt_end) begin
                    next_state = ST_DONE;
                end
            end
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= ST_IDLE;
            ready_q  <= 1'b0;
            prog_q   <= '0;
            beat_cnt <= '0;
        end else begin
            state   <= next_state;
            ready_q <= (next_state == ST_IDLE);
            if (cmd_accept) begin
                prog_q   <= rd_cmd_prog;
                beat_cnt <= '0;
            end else if (issue_fire) begin
                beat_cnt <= beat_cnt + BEAT_CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_flight <= '0;
        end else begin
            case ({issue_fire, beat_push})
                2'b10:   in_flight <= in_flight + CNT_W'(1);
                2'b01:   in_flight <= (in_flight != '0) ? in_flight - CNT_W'(1) : in_flight;
                default: in_flight <= in_flight;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NPROG; i++) begin
                rd_ptr_h[i] <= '0;
            end
        end else if (state == ST_DONE) begin
            rd_ptr_h[prog_q] <= rd_ptr_h[prog_q] + ADDR_WIDTH'(1);
        end
    end

    ddr_rd_beat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (128)
    ) u_beat_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (beat_push),
        .push_data (ddr_rd_data),
        .pop       (beat_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Serializer walks the FIFO head in place; the beat is popped with its last word.
    assign ser_valid     = !fifo_empty;
    assign ser_beat_last = (ser_beat == BEAT_CNT_WIDTH'(NBEATS - 1));
    assign ser_word_last = (word_idx == 2'd3) || (ser_beat_last && (word_idx == 2'(LAST_BEAT_WORDS - 1)));
    assign beat_pop      = ser_valid && ser_word_last;
    assign ser_pkt_end   = beat_pop && ser_beat_last;
    assign ser_first     = ser_valid && (ser_beat == '0) && (word_idx == 2'd0);

    always_comb begin
        case (word_idx)
            2'd0:    ser_word = fifo_head[127:96];
            2'd1:    ser_word = fifo_head[95:64];
            2'd2:    ser_word = fifo_head[63:32];
            default: ser_word = fifo_head[31:0];
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_idx <= '0;
            ser_beat <= '0;
        end else if (ser_valid) begin
            if (ser_word_last) begin
                word_idx <= '0;
                ser_beat <= ser_beat_last ? '0 : ser_beat + BEAT_CNT_WIDTH'(1);
            end else begin
                word_idx <= word_idx + 2'd1;
            end
        end
    end

`ifdef DDR_RD_MARKER_CHECK_EN
    logic bad_marker;
    logic drop_q;

    // A packet whose first beat lacks the writer's start marker is swallowed
    // whole; the FSM still tracks its end so the pointer advances.
    assign bad_marker = ser_first && !fifo_head[127];
    assign drop_now   = bad_marker || drop_q;
    assign pkt_err    = bad_marker;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            drop_q <= 1'b0;
        end else if (ser_pkt_end) begin
            drop_q <= 1'b0;
        end else if (bad_marker) begin
            drop_q <= 1'b1;
        end
    end
`else
    assign drop_now = 1'b0;
    assign pkt_err  = 1'b0;
`endif

    assign ts_out_valid = ser_valid && !drop_now;
    assign ts_out_start = ser_first && !drop_now;
    assign ts_out_end   = ser_pkt_end && !drop_now;
    assign ts_out_data  = !ts_out_valid ? 32'd0 :
                          ser_first     ? {1'b0, ser_word[30:0]} : ser_word;

endmodule

// File: tb/tb_ddr_read_bit128to32.sv
// Directed bench for ddr_read_bit128to32 with a behavioural DDR3 read port
// (configurable ack stall and return latency) and an output capture queue.
module tb_ddr_read_bit128to32;
    import ddr_rw_pkg::*;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd_cmd_valid = 1'b0;
    logic [8:0]   rd_cmd_prog = '0;
    logic         rd_cmd_ready;
    logic         ddr_rd_req;
    logic [27:0]  ddr_rd_addr;
    logic         ddr_rd_ack = 1'b0;
    logic [127:0] ddr_rd_data = '0;
    logic         ddr_rd_data_valid = 1'b0;
    logic [31:0]  ts_out_data;
    logic         ts_out_valid;
    logic         ts_out_start;
    logic         ts_out_end;
    logic         pkt_err;
    rd_state_t    dbg_state;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    ddr_read_bit128to32 #(.FIFO_DEPTH(4)) dut (
        .clk               (clk),
        .rst               (rst),
        .rd_cmd_valid      (rd_cmd_valid),
        .rd_cmd_prog       (rd_cmd_prog),
        .rd_cmd_ready      (rd_cmd_ready),
        .ddr_rd_req        (ddr_rd_req),
        .ddr_rd_addr       (ddr_rd_addr),
        .ddr_rd_ack        (ddr_rd_ack),
        .ddr_rd_data       (ddr_rd_data),
        .ddr_rd_data_valid (ddr_rd_data_valid),
        .ts_out_data       (ts_out_data),
        .ts_out_valid      (ts_out_valid),
        .ts_out_start      (ts_out_start),
        .ts_out_end        (ts_out_end),
        .pkt_err           (pkt_err),
        .dbg_state         (dbg_state)
    );

    int checks = 0;
    int errors = 0;

    // DDR model configuration
    int          lat = 1;
    int          stall_beat = -1;
    int          stall_left = 0;
    bit          bad_en = 1'b0;
    logic [27:0] bad_addr = '0;

    // Capture / scoreboard state
    logic [31:0] exp_q[$];
    logic [27:0] exp_addr[$];
    logic [27:0] addr_log[$];
    logic [31:0] got_data[$];
    bit          got_start[$];
    bit          got_end[$];
    logic [27:0] pend_addr[$];
    int          pend_due[$];
    int          first_req_cyc, first_dv_cyc, first_ts_cyc, last_ts_cyc, end_cyc;
    int          acc_cyc, rdy_cyc;
    int          err_pulses, acks_set, beats_done, max_out, out_idx;
    int          hold_cnt;
    logic [27:0] hold_addr;
    bit          hold_bad;

    function automatic logic [27:0] beat_addr(input int prog, input int ptr, input int b);
        return {1'b0, 9'(prog), 11'(ptr), 4'(b), 3'b000};
    endfunction

    function automatic logic [31:0] src_word(input logic [27:0] a, input int k);
        return {1'b1, 3'(k), a};
    endfunction

    function automatic logic [127:0] mk_beat(input logic [27:0] a);
        logic [127:0] d;
        d = {src_word(a, 0), src_word(a, 1), src_word(a, 2), src_word(a, 3)};
        if (bad_en && (a == bad_addr)) d[127] = 1'b0;
        return d;
    endfunction

    // DDR read port responder and output monitor, all at the falling edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                ddr_rd_ack = 1'b0;
                ddr_rd_data_valid = 1'b0;
                pend_addr.delete();
                pend_due.delete();
            end else begin
                if (acks_set - beats_done > max_out) max_out = acks_set - beats_done;
                if (pkt_err) err_pulses++;
                if (ts_out_valid) begin
                    got_data.push_back(ts_out_data);
                    got_start.push_back(ts_out_start);
                    got_end.push_back(ts_out_end);
                    if (first_ts_cyc < 0) first_ts_cyc = cyc;
                    last_ts_cyc = cyc;
                    if (((out_idx % 4) == 3) || ts_out_end) beats_done++;
                    out_idx++;
                    if (ts_out_end) begin
                        end_cyc = cyc;
                        out_idx = 0;
                    end
                end
                if ((pend_due.size() > 0) && (pend_due[0] <= cyc)) begin
                    ddr_rd_data_valid = 1'b1;
                    ddr_rd_data = mk_beat(pend_addr.pop_front());
                    void'(pend_due.pop_front());
                    if (first_dv_cyc < 0) first_dv_cyc = cyc;
                end else begin
                    ddr_rd_data_valid = 1'b0;
                    ddr_rd_data = '0;
                end
                ddr_rd_ack = 1'b0;
                if (ddr_rd_req) begin
                    if (first_req_cyc < 0) first_req_cyc = cyc;
                    if ((stall_left > 0) && (ddr_rd_addr[6:3] == 4'(stall_beat))) begin
                        if (hold_cnt == 0) hold_addr = ddr_rd_addr;
                        else if (ddr_rd_addr !== hold_addr) hold_bad = 1'b1;
                        hold_cnt++;
                        stall_left--;
                    end else begin
                        ddr_rd_ack = 1'b1;
                        addr_log.push_back(ddr_rd_addr);
                        pend_addr.push_back(ddr_rd_addr);
                        pend_due.push_back(cyc + lat);
                        acks_set++;
                    end
                end else if ((hold_cnt > 0) && (stall_left > 0)) begin
                    hold_bad = 1'b1;
                end
            end
        end
    end

    task automatic build_exp(input int prog, input int ptr);
        logic [31:0] w;
        exp_q.delete();
        exp_addr.delete();
        for (int b = 0; b < 12; b++) begin
            exp_addr.push_back(beat_addr(prog, ptr, b));
            for (int k = 0; k < ((b == 11) ? 3 : 4); k++) begin
                w = src_word(beat_addr(prog, ptr, b), k);
                if ((b == 0) && (k == 0)) w[31] = 1'b0;
                exp_q.push_back(w);
            end
        end
    endtask

    // Issues one command and waits until the block is ready again
    task automatic run_pkt(input int prog, output bit to);
        int n;
        to = 1'b0;
        addr_log.delete();
        got_data.delete();
        got_start.delete();
        got_end.delete();
        first_req_cyc = -1; first_dv_cyc = -1; first_ts_cyc = -1;
        last_ts_cyc = -1; end_cyc = -1;
        err_pulses = 0; acks_set = 0; beats_done = 0; max_out = 0; out_idx = 0;
        hold_cnt = 0; hold_bad = 1'b0;
        @(negedge clk);
        n = 0;
        while (!rd_cmd_ready && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) begin
            to = 1'b1;
            return;
        end
        rd_cmd_valid = 1'b1;
        rd_cmd_prog = 9'(prog);
        acc_cyc = cyc;
        @(negedge clk);
        rd_cmd_valid = 1'b0;
        n = 0;
        while (!rd_cmd_ready && (n < 3000)) begin
            @(negedge clk);
            n++;
        end
        rdy_cyc = cyc;
        if (n >= 3000) to = 1'b1;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if (rd_cmd_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", rd_cmd_ready); end
        checks++; if (ddr_rd_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b expected 0", ddr_rd_req); end
        checks++; if (ddr_rd_addr !== 28'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ddr_rd_addr); end
        checks++; if ({ts_out_valid, ts_out_start, ts_out_end, pkt_err} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b expected 0000", {ts_out_valid, ts_out_start, ts_out_end, pkt_err}); end
        checks++; if (ts_out_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", ts_out_data); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_cmd_ready !== 1'b1) begin errors++; $display("FAIL ready_after_reset: got %b expected 1", rd_cmd_ready); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL state_after_reset: got %0d expected %0d", dbg_state, ST_IDLE); end
    endtask

    task automatic test_prog5_fresh;
        bit to;
        int ns, ne;
        lat = 1;
        build_exp(5, 0);
        run_pkt(5, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL p5_timeout: got %b expected 0", to); end
        checks++; if (addr_log.size() !== 12) begin errors++; $display("FAIL p5_nbeats: got %0d expected 12", addr_log.size()); end
        for (int i = 0; i < addr_log.size() && i < 12; i++) begin
            checks++; if (addr_log[i] !== exp_addr[i]) begin errors++; $display("FAIL p5_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
        end
        checks++; if ((addr_log.size() > 0) && (addr_log[0] !== 28'h0140000)) begin errors++; $display("FAIL p5_addr0: got %h expected 0140000", addr_log[0]); end
        checks++; if (got_data.size() !== 47) begin errors++; $display("FAIL p5_nwords: got %0d expected 47", got_data.size()); end
        ns = 0; ne = 0;
        for (int i = 0; i < got_data.size() && i < 47; i++) begin
            checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL p5_word[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
            ns += int'(got_start[i]);
            ne += int'(got_end[i]);
        end
        if (got_data.size() == 47) begin
            checks++; if (got_data[0] !== 32'h0014_0000) begin errors++; $display("FAIL p5_first_word: got %h expected 00140000", got_data[0]); end
            checks++; if (got_data[46] !== 32'hA014_0058) begin errors++; $display("FAIL p5_word47: got %h expected a0140058", got_data[46]); end
            checks++; if ((got_start[0] !== 1'b1) || (ns !== 1)) begin errors++; $display("FAIL p5_start: got first=%b count=%0d expected 1/1", got_start[0], ns); end
            checks++; if ((got_end[46] !== 1'b1) || (ne !== 1)) begin errors++; $display("FAIL p5_end: got last=%b count=%0d expected 1/1", got_end[46], ne); end
        end
        checks++; if (first_req_cyc !== acc_cyc + 1) begin errors++; $display("FAIL p5_req_latency: got %0d expected %0d", first_req_cyc, acc_cyc + 1); end
        checks++; if (first_ts_cyc !== first_dv_cyc + 1) begin errors++; $display("FAIL p5_ts_latency: got %0d expected %0d", first_ts_cyc, first_dv_cyc + 1); end
        checks++; if (last_ts_cyc - first_ts_cyc !== 46) begin errors++; $display("FAIL p5_gapfree: got span %0d expected 46", last_ts_cyc - first_ts_cyc); end
        checks++; if (rdy_cyc !== end_cyc + 2) begin errors++; $display("FAIL p5_ready_return: got %0d expected %0d", rdy_cyc, end_cyc + 2); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL p5_pkt_err: got %0d expected 0", err_pulses); end
        checks++; if (max_out > 4) begin errors++; $display("FAIL p5_credit: got %0d expected <=4", max_out); end
    endtask

    task automatic test_pointer_advance;
        bit to;
        build_exp(5, 1);
        run_pkt(5, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL p5b_timeout: got %b expected 0", to); end
        checks++; if ((addr_log.size() < 1) || (addr_log[0] !== 28'h0140080)) begin errors++; $display("FAIL p5b_addr0: got %h expected 0140080", (addr_log.size() > 0) ? addr_log[0] : 28'hx); end
        checks++; if (got_data.size() !== 47) begin errors++; $display("FAIL p5b_nwords: got %0d expected 47", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 47; i++) begin
            checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL p5b_word[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
        end
        build_exp(6, 0);
        run_pkt(6, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL p6_timeout: got %b expected 0", to); end
        checks++; if ((addr_log.size() < 1) || (addr_log[0] !== 28'h0180000)) begin errors++; $display("FAIL p6_addr0: got %h expected 0180000", (addr_log.size() > 0) ? addr_log[0] : 28'hx); end
        checks++; if ((got_data.size() < 47) || (got_data[46] !== exp_q[46])) begin errors++; $display("FAIL p6_word47: got %h expected %h", (got_data.size() > 46) ? got_data[46] : 32'hx, exp_q[46]); end
    endtask

    task automatic test_ack_hold;
        bit to;
        lat = 1;
        stall_beat = 3;
        stall_left = 10;
        build_exp(7, 0);
        run_pkt(7, to);
        stall_beat = -1;
        stall_left = 0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL hold_timeout: got %b expected 0", to); end
        checks++; if (hold_cnt !== 10) begin errors++; $display("FAIL hold_cycles: got %0d expected 10", hold_cnt); end
        checks++; if (hold_bad !== 1'b0) begin errors++; $display("FAIL hold_stable: got %b expected 0", hold_bad); end
        checks++; if (hold_addr !== beat_addr(7, 0, 3)) begin errors++; $display("FAIL hold_addr: got %h expected %h", hold_addr, beat_addr(7, 0, 3)); end
        checks++; if (max_out > 4) begin errors++; $display("FAIL hold_credit: got %0d expected <=4", max_out); end
        checks++; if (addr_log.size() !== 12) begin errors++; $display("FAIL hold_nbeats: got %0d expected 12", addr_log.size()); end
        for (int i = 0; i < addr_log.size() && i < 12; i++) begin
            checks++; if (addr_log[i] !== exp_addr[i]) begin errors++; $display("FAIL hold_addr[%0d]: got %h expected %h", i, addr_log[i], exp_addr[i]); end
        end
        checks++; if (got_data.size() !== 47) begin errors++; $display("FAIL hold_nwords: got %0d expected 47", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 47; i++) begin
            checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL hold_word[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_slow_return;
        bit to;
        lat = 20;
        build_exp(9, 0);
        run_pkt(9, to);
        lat = 1;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL slow_timeout: got %b expected 0", to); end
        checks++; if (got_data.size() !== 47) begin errors++; $display("FAIL slow_nwords: got %0d expected 47", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 47; i++) begin
            checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL slow_word[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
        end
        checks++; if (first_ts_cyc !== first_dv_cyc + 1) begin errors++; $display("FAIL slow_ts_latency: got %0d expected %0d", first_ts_cyc, first_dv_cyc + 1); end
        checks++; if (max_out > 4) begin errors++; $display("FAIL slow_credit: got %0d expected <=4", max_out); end
        checks++; if ((got_end.size() < 47) || (got_end[46] !== 1'b1)) begin errors++; $display("FAIL slow_end: got %0d words expected end on word 47", got_end.size()); end
    endtask

    task automatic test_marker;
        bit to;
        bad_en = 1'b1;
        bad_addr = beat_addr(10, 0, 0);
        build_exp(10, 0);
        run_pkt(10, to);
        bad_en = 1'b0;
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL marker_timeout: got %b expected 0", to); end
`ifdef DDR_RD_MARKER_CHECK_EN
        checks++; if (err_pulses !== 1) begin errors++; $display("FAIL marker_err_pulses: got %0d expected 1", err_pulses); end
        checks++; if (got_data.size() !== 0) begin errors++; $display("FAIL marker_dropped: got %0d words expected 0", got_data.size()); end
        build_exp(10, 1);
        run_pkt(10, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL marker_next_timeout: got %b expected 0", to); end
        checks++; if ((addr_log.size() < 1) || (addr_log[0] !== 28'h0280080)) begin errors++; $display("FAIL marker_next_addr0: got %h expected 0280080", (addr_log.size() > 0) ? addr_log[0] : 28'hx); end
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL marker_next_err: got %0d expected 0", err_pulses); end
`else
        checks++; if (err_pulses !== 0) begin errors++; $display("FAIL marker_err_tied: got %0d expected 0", err_pulses); end
        checks++; if ((got_data.size() < 1) || (got_data[0] !== 32'h0028_0000)) begin errors++; $display("FAIL marker_first_word: got %h expected 00280000", (got_data.size() > 0) ? got_data[0] : 32'hx); end
`endif
        checks++; if (got_data.size() !== 47) begin errors++; $display("FAIL marker_nwords: got %0d expected 47", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 47; i++) begin
            checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL marker_word[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
        end
    endtask

    task automatic test_reset_mid;
        bit to;
        int n;
        @(negedge clk);
        n = 0;
        while (!rd_cmd_ready && (n < 100)) begin
            @(negedge clk);
            n++;
        end
        rd_cmd_valid = 1'b1;
        rd_cmd_prog = 9'd5;
        @(negedge clk);
        rd_cmd_valid = 1'b0;
        repeat (15) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (rd_cmd_ready !== 1'b0) begin errors++; $display("FAIL midrst_ready: got %b expected 0", rd_cmd_ready); end
        checks++; if ({ddr_rd_req, ts_out_valid, pkt_err} !== 3'b000) begin errors++; $display("FAIL midrst_outputs: got %b expected 000", {ddr_rd_req, ts_out_valid, pkt_err}); end
        checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL midrst_state: got %0d expected %0d", dbg_state, ST_IDLE); end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (rd_cmd_ready !== 1'b1) begin errors++; $display("FAIL midrst_ready_after: got %b expected 1", rd_cmd_ready); end
        build_exp(5, 0);
        run_pkt(5, to);
        checks++; if (to !== 1'b0) begin errors++; $display("FAIL midrst_timeout: got %b expected 0", to); end
        checks++; if ((addr_log.size() < 1) || (addr_log[0] !== 28'h0140000)) begin errors++; $display("FAIL midrst_ptr_cleared: got %h expected 0140000", (addr_log.size() > 0) ? addr_log[0] : 28'hx); end
        checks++; if (got_data.size() !== 47) begin errors++; $display("FAIL midrst_nwords: got %0d expected 47", got_data.size()); end
        for (int i = 0; i < got_data.size() && i < 47; i++) begin
            checks++; if (got_data[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_word[%0d]: got %h expected %h", i, got_data[i], exp_q[i]); end
        end
    endtask

    initial begin
        test_reset();
        test_prog5_fresh();
        test_pointer_advance();
        test_ack_hold();
        test_slow_return();
        test_marker();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/ddr_read_bit128to32.md
# ddr_read_bit128to32

Read-side counterpart of the DDR3 TS packet writer. On a per-program read command it fetches one stored TS packet from DDR3 as 128-bit beats, using the same address map the writer uses. It serializes the beats back into a 32-bit TS word stream with start/end strobes and restores the sync word the writer marked. It sits between the output scheduler and the DDR3 user read port, feeding the 32-bit TS output path.

## Interface
- U_DLY, 1: simulation delay on registered assignments
- DDR3_ADDR_WIDTH, 28: DDR3 user address width
- PROG_BIT_WIDTH, 9: program index width (512 programs)
- ADDR_WIDTH, 20-PROG_BIT_WIDTH: per-program packet pointer width (11)
- PKT_WORDS, 47: 32-bit words per TS packet (188 bytes)
- FIFO_DEPTH, 4: beat buffer depth, also max beats in flight
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- rd_cmd_valid  in  1  scheduler requests one packet
- rd_cmd_prog  in  PROG_BIT_WIDTH  program to read
- rd_cmd_ready  out  1  high in IDLE only
- ddr_rd_req  out  1  beat read request, held until ddr_rd_ack
- ddr_rd_addr  out  DDR3_ADDR_WIDTH  beat address
- ddr_rd_ack  in  1  request accepted this cycle
- ddr_rd_data  in  128  returned beat
- ddr_rd_data_valid  in  1  beat valid, in request order
- ts_out_data  out  32  TS word
- ts_out_valid  out  1  word valid
- ts_out_start  out  1  first word of packet
- ts_out_end  out  1  last word of packet
- pkt_err  out  1  one-cycle pulse on marker mismatch

## Operation
- Beats per packet: NBEATS = ceil(PKT_WORDS/4) = 12. The last beat carries PKT_WORDS-4*(NBEATS-1) = 3 valid words in bits [127:32].
- Address: {1'b0, prog, rd_ptr_h[prog], beat_cnt[3:0], 3'b000}, which is 1+9+11+4+3 = 28 bits.
- rd_ptr_h: one ADDR_WIDTH register per program, reset 0. It increments by 1 (mod 2^ADDR_WIDTH, 2047→0) when that program's packet completes.
- FSM states:
  - IDLE: rd_cmd_ready=1. On rd_cmd_valid, latch prog, clear beat_cnt and issued count, go to ISSUE.
  - ISSUE: assert ddr_rd_req when credit allows (in_flight + fifo_count < FIFO_DEPTH). On ddr_rd_ack, beat_cnt+1. After beat NBEATS-1 is acked, go to DRAIN.
  - DRAIN: wait until the serializer emits the word with ts_out_end, then go to DONE.
  - DONE: rd_ptr_h[prog]+1, go to IDLE.
- ddr_rd_req and ddr_rd_addr are stable while req is high and ack is low.
- in_flight: +1 on ack, -1 on ddr_rd_data_valid. Both in the same cycle leaves it unchanged.
- Returned beats are pushed into the beat FIFO. Push and pop in the same cycle are legal. Overflow cannot occur under the credit rule.
- Serializer: pops a beat when idle or on the last word of the current beat. It emits words [127:96], [95:64], [63:32], [31:0], one per cycle. On beat NBEATS-1 it stops after 3 words.
- First word: ts_out_start=1, and bit 31 is forced to 0 (the writer's start marker is removed).
- Word PKT_WORDS: ts_out_end=1.
- ddr_rd_data_valid outside ISSUE/DRAIN is ignored.
- Reset mid-operation: FSM returns to IDLE, FIFO is emptied, all rd_ptr_h are cleared. The DDR controller is reset together with this block.

## Timing
- Reset values: rd_cmd_ready=0 during reset and 1 the first cycle after; ddr_rd_req=0; ddr_rd_addr=0; ts_out_*=0; pkt_err=0.
- Command accepted at cycle N. ddr_rd_req is first high at N+1.
- First TS word: one cycle after the first ddr_rd_data_valid.
- Output is gap-free while the FIFO is non-empty, and there is no output backpressure.
- rd_cmd_ready returns 2 cycles after ts_out_end (DONE, then IDLE).

## Configuration
- DDR_RD_MARKER_CHECK_EN defined:
  - Bit 127 of beat 0 must be 1.
  - If it is 0, pkt_err pulses with the first serialized word and the packet is dropped: ts_out_valid, ts_out_start and ts_out_end stay 0 for that packet.
  - The pointer still advances.
- Not defined: no check; bit 31 is forced to 0 and pkt_err is tied 0.

## Structure
- Package ddr_rw_pkg holds DDR3_ADDR_WIDTH, PROG_BIT_WIDTH, ADDR_WIDTH, PKT_WORDS, the NBEATS function, and the FSM state enum. The writer shares the address-width constants.
- Sub-module ddr_rd_beat_fifo: synchronous FIFO_DEPTH×128 with count output.
- rd_ptr_h: a register array indexed by prog.

## Test plan
- Reset: all outputs at reset values; rd_cmd_ready=1 one cycle after deassertion.
- Program 5, fresh pointer:
  - addresses are {0,5,0,b,000} for b=0..11;
  - 47 words out, start on word 1 with bit31=0, end on word 47;
  - word 47 equals beat 11 [63:32].
- Second command to program 5 uses rd_ptr_h=1. Program 6 still reads pointer 0.
- Hold ddr_rd_ack low for 10 cycles at beat 3: req and address stay stable, no extra beats are issued, and in_flight+fifo never exceeds 4.
- Delay all data returns by 20 cycles: output remains 47 contiguous words with correct order.
- With DDR_RD_MARKER_CHECK_EN, beat 0 has bit127=0: one pkt_err pulse, no ts_out_valid, and the next read of that program uses pointer+1.
